// File: rtl/led_seq_pkg.sv
// Purpose: shared types and constants for the LED pattern sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_seq_pkg;

    // Sequencer control states; the completion pulse is a separate register.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // Morse "SOS" over 30 slots.
    // Set bits: 0,2,4 (S), 6-8,12-14,18-20 (O), 24,26,28 (S).
    localparam logic [29:0] SOS_PATTERN = 30'h151C_71D5;

    // Width of a channel-select field; at least one bit even for one channel.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_seq_tick.sv
// Purpose: slot-period prescaler; pulses tick once every div+1 clocks.
// Latency: tick is combinational from the counter; counter clears on tick or clr.
// Backpressure: none; clr holds the counter at zero.
//
// Ports: clk, rstn (async active-low), clr (synchronous clear),
//        div (period minus one), tick (high in the last cycle of a period).
module led_seq_tick #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // ">=" rather than "==" so that lowering div mid-period cannot leave the
    // counter above the new limit and force a full 2^DIV_W wrap.
    assign tick = (cnt >= div);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// Purpose: plays a per-channel LEN-slot on/off pattern onto CH LEDs, one-shot or looping.
// Latency: start -> slot 0 on led/busy after one clk; each slot lasts div+1 clks.
// Backpressure: none; stop beats start beats tick, pattern writes are always accepted.
//
// Ports: clk, rstn (async active-low); div (slot period - 1); pat_we/pat_ch/pat_data
//        (pattern write, out-of-range channel ignored); start, stop, loop (latched on
//        start); busy (high in RUN), done (one-clk pulse at one-shot end), led[CH].
// Build option: define LED_SEQ_PWM_EN to add the pwm_duty input and dim every LED
//        with a free-running 8-bit PWM (on while counter < pwm_duty).
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int              CH       = 1,
    parameter int              LEN      = 30,
    parameter int              DIV_W    = 24,
    parameter logic [63:0]     INIT_PAT = 64'(SOS_PATTERN)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [DIV_W-1:0]          div,
    input  logic                      pat_we,
    input  logic [sel_width(CH)-1:0]  pat_ch,
    input  logic [LEN-1:0]            pat_data,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      loop,
    output logic                      busy,
    output logic                      done,
`ifdef LED_SEQ_PWM_EN
    input  logic [7:0]                pwm_duty,
`endif
    output logic [CH-1:0]             led
);

    localparam int CH_W   = sel_width(CH);
    localparam int SLOT_W = $clog2(LEN);

    seq_state_t          state;
    logic [SLOT_W-1:0]   slot;
    logic                loop_q;
    logic                tick;
    logic                tick_clr;
    logic                pwm_gate;
    logic [LEN-1:0]      pat     [CH];
    logic [LEN-1:0]      pat_nxt [CH];

    // Prescaler only runs in RUN; start/stop restart it so slot 0 gets a full period.
    assign tick_clr = (state != RUN) || start || stop;

    led_seq_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (tick_clr),
        .div   (div),
        .tick  (tick)
    );

`ifdef LED_SEQ_PWM_EN
    logic [7:0] pwm_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    // led is registered, so gate against the counter value of the coming cycle.
    assign pwm_gate = ((pwm_cnt + 8'd1) < pwm_duty);
`else
    assign pwm_gate = 1'b1;
`endif

    // Pattern contents as they will be after this edge; led is computed from this
    // so a write to the slot on display shows up in the same cycle as the new pattern.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            pat_nxt[c] = pat[c];
            if (pat_we && (pat_ch == CH_W'(c))) begin
                pat_nxt[c] = pat_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < CH; c++) begin
                pat[c] <= INIT_PAT[LEN-1:0];
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                pat[c] <= pat_nxt[c];
            end
        end
    end

    function automatic logic [CH-1:0] led_bits(input logic [SLOT_W-1:0] s);
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) begin
            v[c] = pat_nxt[c][s] & pwm_gate;
        end
        return v;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            slot   <= '0;
            loop_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            led    <= '0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state <= IDLE;
                slot  <= '0;
                busy  <= 1'b0;
                led   <= '0;
            end else if (start) begin
                state  <= RUN;
                slot   <= '0;
                loop_q <= loop;
                busy   <= 1'b1;
                led    <= led_bits('0);
            end else if (state == RUN) begin
                if (tick && (slot == SLOT_W'(LEN - 1))) begin
                    if (loop_q) begin
                        slot <= '0;
                        led  <= led_bits('0);
                    end else begin
                        state <= IDLE;
                        slot  <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        led   <= '0;
                    end
                end else if (tick) begin
                    slot <= slot + SLOT_W'(1);
                    led  <= led_bits(slot + SLOT_W'(1));
                end else begin
                    led  <= led_bits(slot);
                end
            end else begin
                slot <= '0;
                busy <= 1'b0;
                led  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Purpose: directed scoreboard bench for led_sequencer (CH=2, LEN=30, default build).
// Latency: expectations are due one clk after the inputs that cause them.
// Backpressure: n/a.
module tb_led_sequencer;

    localparam int CH    = 2;
    localparam int LEN   = 30;
    localparam int DIV_W = 24;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [DIV_W-1:0]  div = '0;
    logic              pat_we = 1'b0;
    logic [0:0]        pat_ch = '0;
    logic [LEN-1:0]    pat_data = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop = 1'b0;
    logic              busy;
    logic              done;
    logic [CH-1:0]     led;

    // SOS written out bit by bit from the slot list 0,2,4,6,7,8,12,13,14,18,19,20,24,26,28.
    logic [LEN-1:0]    sos;
    logic [LEN-1:0]    ones;

    typedef struct {
        string        name;
        int unsigned  due;
        logic [CH-1:0] led;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    led_sequencer #(
        .CH    (CH),
        .LEN   (LEN),
        .DIV_W (DIV_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .div      (div),
        .pat_we   (pat_we),
        .pat_ch   (pat_ch),
        .pat_data (pat_data),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .busy     (busy),
        .done     (done),
        .led      (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [CH-1:0] el, input logic eb, input logic ed);
        vectors++;
        if (led !== el || busy !== eb || done !== ed) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got led=%b busy=%b done=%b expected led=%b busy=%b done=%b",
                     name, cyc, led, busy, done, el, eb, ed);
        end
    endtask

    // Monitor: samples on the falling edge, pops every expectation due this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due != cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL %s stale expectation due=%0d now=%0d", e.name, e.due, cyc);
            end else begin
                check(e.name, e.led, e.busy, e.done);
            end
        end
    end

    // Queue the outputs expected after the next rising edge, then cross that edge.
    task automatic expect_next(input string name, input logic [CH-1:0] el, input logic eb, input logic ed);
        exp_t e;
        e.name = name;
        e.due  = cyc + 1;
        e.led  = el;
        e.busy = eb;
        e.done = ed;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CH-1:0] led_of(input logic [LEN-1:0] p1, input logic [LEN-1:0] p0, input int s);
        return {p1[s], p0[s]};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sos = '0;
        foreach (sos[i]) begin
            if (i inside {0, 2, 4, 6, 7, 8, 12, 13, 14, 18, 19, 20, 24, 26, 28}) sos[i] = 1'b1;
        end
        ones = '1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset", 2'b00, 1'b0, 1'b0);
        rstn = 1'b1;
        expect_next("idle", 2'b00, 1'b0, 1'b0);
        expect_next("idle", 2'b00, 1'b0, 1'b0);

        // start together with stop: stop wins, stay idle
        start = 1'b1; stop = 1'b1;
        expect_next("start_stop_idle", 2'b00, 1'b0, 1'b0);
        start = 1'b0; stop = 1'b0;

        // One-shot, div=0: SOS on both channels, one slot per clk, then done
        div = '0; loop = 1'b0; start = 1'b1;
        expect_next("os_slot0", led_of(sos, sos, 0), 1'b1, 1'b0);
        start = 1'b0;
        for (int s = 1; s < LEN; s++) expect_next("os_slot", led_of(sos, sos, s), 1'b1, 1'b0);
        expect_next("os_done", 2'b00, 1'b0, 1'b1);
        expect_next("os_after", 2'b00, 1'b0, 1'b0);

        // Looping, div=3: 4 clk per slot, seamless 29->0 wrap, stop in slot 10
        div = 24'd3; loop = 1'b1; start = 1'b1;
        expect_next("loop_k0", led_of(sos, sos, 0), 1'b1, 1'b0);
        start = 1'b0;
        for (int k = 1; k <= 160; k++) expect_next("loop_slot", led_of(sos, sos, (k / 4) % LEN), 1'b1, 1'b0);
        stop = 1'b1;
        expect_next("stop", 2'b00, 1'b0, 1'b0);
        stop = 1'b0;
        repeat (3) expect_next("post_stop", 2'b00, 1'b0, 1'b0);

        // Pattern write to ch1 while running, then restart as one-shot
        div = '0; loop = 1'b1; start = 1'b1;
        expect_next("we_slot0", led_of(sos, sos, 0), 1'b1, 1'b0);
        start = 1'b0;
        for (int s = 1; s <= 5; s++) expect_next("we_pre", led_of(sos, sos, s), 1'b1, 1'b0);
        pat_we = 1'b1; pat_ch = 1'b1; pat_data = ones;
        expect_next("we_apply", led_of(ones, sos, 6), 1'b1, 1'b0);
        pat_we = 1'b0;
        for (int s = 7; s <= 12; s++) expect_next("we_post", led_of(ones, sos, s), 1'b1, 1'b0);
        loop = 1'b0; start = 1'b1;
        expect_next("restart_slot0", led_of(ones, sos, 0), 1'b1, 1'b0);
        start = 1'b0;
        for (int s = 1; s < LEN; s++) expect_next("restart_slot", led_of(ones, sos, s), 1'b1, 1'b0);
        expect_next("restart_done", 2'b00, 1'b0, 1'b1);
        expect_next("restart_after", 2'b00, 1'b0, 1'b0);

        // Asynchronous reset mid-run: outputs drop at once, patterns return to SOS
        loop = 1'b1; start = 1'b1;
        expect_next("rst_run0", led_of(ones, sos, 0), 1'b1, 1'b0);
        start = 1'b0;
        expect_next("rst_run1", led_of(ones, sos, 1), 1'b1, 1'b0);
        expect_next("rst_run2", led_of(ones, sos, 2), 1'b1, 1'b0);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("async_rst", 2'b00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("rst_hold", 2'b00, 1'b0, 1'b0);
        rstn = 1'b1;
        expect_next("rst_wait", 2'b00, 1'b0, 1'b0);
        expect_next("rst_wait", 2'b00, 1'b0, 1'b0);
        loop = 1'b0; start = 1'b1;
        expect_next("rst_sos0", led_of(sos, sos, 0), 1'b1, 1'b0);
        start = 1'b0;
        for (int s = 1; s < LEN; s++) expect_next("rst_sos", led_of(sos, sos, s), 1'b1, 1'b0);
        expect_next("rst_done", 2'b00, 1'b0, 1'b1);
        expect_next("rst_after", 2'b00, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain %0d expectations never checked, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
